fetch_unit: RTL and testbench

Instruction-fetch stage that drives the 8-bit byte address of the 128x16 instruction RAM and registers the returned word into a fetch/decode pipeline register.
Owns the program counter, the RAM boot-load window, stall and redirect (branch/jump) handling, and end-of-memory halt.
Sits between the instruction RAM and the decode stage.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, RAM boot window, stall/redirect, end-of-memory halt
module fetch_unit #(
    parameter int BOOT_CYCLES = 2,
    parameter bit WRAP_EN     = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [7:0]  IMEM_ADDR,
    output logic        IMEM_INIT,
    input  logic [15:0] IMEM_Q,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [7:0]  REDIRECT_PC,
    output logic [15:0] IF_INSTR,
    output logic [7:0]  IF_PC,
    output logic        IF_VALID,
    output logic        HALTED
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    // Last boot counter value; the edge that sees it leaves BOOT.
    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
    // Word index of byte address 8'hFE, the last instruction slot.
    localparam logic [6:0] LAST_WORD = 7'h7F;

    state_t      state;
    logic [3:0]  boot_cnt;
    // PC and IF_PC are kept as word indices so bit 0 of a byte address can never be set.
    logic [6:0]  pc_word;
    logic [6:0]  ifpc_word;
    logic [15:0] instr_q;
    logic        valid_q;
    logic        halted_q;
    logic        init_q;
    logic [6:0]  target_word;
    logic        unused_redirect_lsb;

    assign target_word         = REDIRECT_PC[7:1];
    assign unused_redirect_lsb = REDIRECT_PC[0];

    assign IMEM_ADDR = {pc_word, 1'b0};
    assign IMEM_INIT = init_q;
    assign IF_INSTR  = instr_q;
    assign IF_PC     = {ifpc_word, 1'b0};
    assign IF_VALID  = valid_q;
    assign HALTED    = halted_q;

    // Fetch FSM: boot window, then fetch with redirect > stall > advance priority.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_BOOT;
            boot_cnt  <= 4'd0;
            pc_word   <= 7'd0;
            ifpc_word <= 7'd0;
            instr_q   <= 16'h0000;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            init_q    <= 1'b1;
        end else begin
            unique case (state)
                S_BOOT: begin
                    // RAM is loading; stall and redirect have nothing to act on yet.
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state  <= S_RUN;
                        init_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (REDIRECT) begin
                        // Flush the word fetched down the wrong path; IF_PC keeps its last value.
                        pc_word <= target_word;
                        instr_q <= 16'h0000;
                        valid_q <= 1'b0;
                    end else if (!STALL) begin
                        instr_q   <= IMEM_Q;
                        ifpc_word <= pc_word;
                        valid_q   <= 1'b1;
                        if (pc_word == LAST_WORD && WRAP_EN == 1'b0) begin
                            // Word at 8'hFE is issued; PC parks there.
                            state    <= S_HALT;
                            halted_q <= 1'b1;
                        end else begin
                            pc_word <= pc_word + 7'd1;
                        end
                    end
                end
                S_HALT: begin
                    if (REDIRECT) begin
                        pc_word  <= target_word;
                        instr_q  <= 16'h0000;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                        state    <= S_RUN;
                    end else if (!STALL) begin
                        // Decode has taken the last word; present NOPs from now on.
                        instr_q <= 16'h0000;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= S_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        stall, redirect;
    logic [7:0]  rpc;

    logic [7:0]  addr0, addr1, ifpc0, ifpc1;
    logic        init0, init1, valid0, valid1, halted0, halted1;
    logic [15:0] q0, q1, instr0, instr1;

    logic [15:0] mem [128];

    int n_checks = 0;
    int n_errors = 0;

    assign q0 = mem[addr0[7:1]];
    assign q1 = mem[addr1[7:1]];

    always #5 CLK = ~CLK;

    fetch_unit #(.BOOT_CYCLES(2), .WRAP_EN(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET), .IMEM_ADDR(addr0), .IMEM_INIT(init0), .IMEM_Q(q0),
        .STALL(stall), .REDIRECT(redirect), .REDIRECT_PC(rpc),
        .IF_INSTR(instr0), .IF_PC(ifpc0), .IF_VALID(valid0), .HALTED(halted0)
    );

    fetch_unit #(.BOOT_CYCLES(3), .WRAP_EN(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET), .IMEM_ADDR(addr1), .IMEM_INIT(init1), .IMEM_Q(q1),
        .STALL(stall), .REDIRECT(redirect), .REDIRECT_PC(rpc),
        .IF_INSTR(instr1), .IF_PC(ifpc1), .IF_VALID(valid1), .HALTED(halted1)
    );

    // Reference model: one entry per DUT instance (0: boot 2 / no wrap, 1: boot 3 / wrap).
    int          m_mode  [2];   // 0 boot, 1 run, 2 halt
    int          m_cnt   [2];
    int          m_pc    [2];
    int          m_ifpc  [2];
    int          m_valid [2];
    int          m_halted[2];
    logic [15:0] m_instr [2];
    int          m_boot  [2] = '{2, 3};
    int          m_wrap  [2] = '{0, 1};

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_pc[k] = 0; m_ifpc[k] = 0;
            m_valid[k] = 0; m_halted[k] = 0; m_instr[k] = 16'h0000;
        end
    endfunction

    function automatic void model_step(input bit st, input bit rd, input int tgt);
        for (int k = 0; k < 2; k++) begin
            if (m_mode[k] == 0) begin
                m_cnt[k]++;
                if (m_cnt[k] == m_boot[k]) m_mode[k] = 1;
            end else if (rd) begin
                m_pc[k] = tgt - (tgt % 2);
                m_instr[k] = 16'h0000;
                m_valid[k] = 0;
                m_halted[k] = 0;
                m_mode[k] = 1;
            end else if (!st) begin
                if (m_mode[k] == 1) begin
                    m_instr[k] = mem[m_pc[k] / 2];
                    m_ifpc[k] = m_pc[k];
                    m_valid[k] = 1;
                    if (m_pc[k] == 254 && m_wrap[k] == 0) begin
                        m_mode[k] = 2;
                        m_halted[k] = 1;
                    end else begin
                        m_pc[k] = (m_pc[k] + 2) % 256;
                    end
                end else begin
                    m_instr[k] = 16'h0000;
                    m_valid[k] = 0;
                end
            end
        end
    endfunction

    task automatic check_out(input string name,
                             input logic [7:0] a, input logic ini, input logic [15:0] ins,
                             input logic [7:0] p, input logic v, input logic h,
                             input logic [7:0] ea, input logic eini, input logic [15:0] eins,
                             input logic [7:0] ep, input logic ev, input logic eh);
        n_checks++;
        if ({a, ini, ins, p, v, h} !== {ea, eini, eins, ep, ev, eh}) begin
            n_errors++;
            $display("FAIL %s @%0t: got addr=%h init=%b instr=%h pc=%h valid=%b halted=%b, want addr=%h init=%b instr=%h pc=%h valid=%b halted=%b",
                     name, $time, a, ini, ins, p, v, h, ea, eini, eins, ep, ev, eh);
        end
    endtask

    task automatic check_model(input string name);
        check_out({name, "/dut0"}, addr0, init0, instr0, ifpc0, valid0, halted0,
                  8'(m_pc[0]), m_mode[0] == 0, m_instr[0], 8'(m_ifpc[0]), m_valid[0] != 0, m_halted[0] != 0);
        check_out({name, "/dut1"}, addr1, init1, instr1, ifpc1, valid1, halted1,
                  8'(m_pc[1]), m_mode[1] == 0, m_instr[1], 8'(m_ifpc[1]), m_valid[1] != 0, m_halted[1] != 0);
    endtask

    task automatic check_reset_state(input string name);
        check_out({name, "/dut0"}, addr0, init0, instr0, ifpc0, valid0, halted0,
                  8'h00, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
        check_out({name, "/dut1"}, addr1, init1, instr1, ifpc1, valid1, halted1,
                  8'h00, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic        st;
        logic        rd;
        logic [7:0]  rpc;
        logic [7:0]  ea;
        logic        ei;
        logic [15:0] eins;
        logic [7:0]  ep;
        logic        ev;
        logic        eh;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic st, input logic rd, input logic [7:0] r,
                                input logic [7:0] ea, input logic ei, input logic [15:0] eins,
                                input logic [7:0] ep, input logic ev, input logic eh);
        vec_t t;
        t.st = st; t.rd = rd; t.rpc = r; t.ea = ea; t.ei = ei;
        t.eins = eins; t.ep = ep; t.ev = ev; t.eh = eh;
        return t;
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h1357) ^ 16'hA5C3;
        mem[0] = 16'hF001; mem[1] = 16'h517F; mem[2] = 16'h2A79; mem[3] = 16'h2ABA;

        //             st    rd    rpc    addr   init  instr        ifpc   valid halted
        tbl[0]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 16'h0000,   8'h00, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b1, 8'h40, 8'h00, 1'b0, 16'h0000,   8'h00, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 16'hF001,   8'h00, 1'b1, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 16'h517F,   8'h02, 1'b1, 1'b0);
        tbl[4]  = mk(1'b0, 1'b0, 8'h00, 8'h06, 1'b0, 16'h2A79,   8'h04, 1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 8'h00, 8'h06, 1'b0, 16'h2A79,   8'h04, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 8'h00, 8'h06, 1'b0, 16'h2A79,   8'h04, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 8'h00, 8'h06, 1'b0, 16'h2A79,   8'h04, 1'b1, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 8'h00, 8'h08, 1'b0, 16'h2ABA,   8'h06, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b1, 8'h19, 8'h18, 1'b0, 16'h0000,   8'h06, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 8'h00, 8'h1A, 1'b0, mem[12],    8'h18, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 8'hFC, 8'hFC, 1'b0, 16'h0000,   8'h18, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, mem[126],   8'hFC, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, mem[127],   8'hFE, 1'b1, 1'b1);
        tbl[14] = mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 16'h0000,   8'hFE, 1'b0, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 16'h0000,   8'hFE, 1'b0, 1'b1);
        tbl[16] = mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 16'h0000,   8'hFE, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 16'hF001,   8'h00, 1'b1, 1'b0);
        tbl[18] = mk(1'b0, 1'b1, 8'hFD, 8'hFC, 1'b0, 16'h0000,   8'h00, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, mem[126],   8'hFC, 1'b1, 1'b0);
        tbl[20] = mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, mem[127],   8'hFE, 1'b1, 1'b1);
        tbl[21] = mk(1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, mem[127],   8'hFE, 1'b1, 1'b1);
        tbl[22] = mk(1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, mem[127],   8'hFE, 1'b1, 1'b1);
        tbl[23] = mk(1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 16'h0000,   8'hFE, 1'b0, 1'b1);

        RESET = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = 8'h00;
        repeat (2) @(negedge CLK);
        check_reset_state("reset_state");
        model_reset();
        RESET = 1'b1;

        for (int i = 0; i < 24; i++) begin
            stall = tbl[i].st; redirect = tbl[i].rd; rpc = tbl[i].rpc;
            @(posedge CLK);
            model_step(tbl[i].st, tbl[i].rd, int'(tbl[i].rpc));
            @(negedge CLK);
            check_out($sformatf("vec%0d", i), addr0, init0, instr0, ifpc0, valid0, halted0,
                      tbl[i].ea, tbl[i].ei, tbl[i].eins, tbl[i].ep, tbl[i].ev, tbl[i].eh);
            check_out($sformatf("vec%0d/dut1", i), addr1, init1, instr1, ifpc1, valid1, halted1,
                      8'(m_pc[1]), m_mode[1] == 0, m_instr[1], 8'(m_ifpc[1]), m_valid[1] != 0, m_halted[1] != 0);
        end

        // Asynchronous reset between edges, mid-run.
        stall = 1'b0; redirect = 1'b0;
        @(posedge CLK);
        model_step(1'b0, 1'b0, 0);
        #2 RESET = 1'b0;
        #1 check_reset_state("async_reset");
        model_reset();
        @(negedge CLK);
        RESET = 1'b1;

        // Boot window repeats after reset: IMEM_INIT for BOOT_CYCLES edges.
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            model_step(1'b0, 1'b0, 0);
            @(negedge CLK);
            check_model($sformatf("reboot%0d", i));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                RESET = 1'b0;
                #1 check_reset_state("rand_reset");
                model_reset();
                @(negedge CLK);
                RESET = 1'b1;
            end
            stall    = ($urandom_range(0, 9) < 3);
            redirect = ($urandom_range(0, 29) == 0);
            rpc      = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'hE0, 8'hFF)) : 8'($urandom);
            @(posedge CLK);
            model_step(stall, redirect, int'(rpc));
            @(negedge CLK);
            check_model($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
